ntt_dit_controller: RTL and testbench

- Sequences a single radix-2 DIT butterfly, one butterfly per cycle, over an in-place NPTS-point NTT held in a dual-port coefficient RAM.
- Generates RAM read addresses, twiddle ROM address and delayed write-back addresses for every butterfly.
- Inserts a drain gap between stages so no read sees stale data.
- Sits between the top-level NTT FSM/host (start/done) and the coefficient RAM, twiddle ROM and butterfly datapath; it carries no coefficient data itself.

---
 rtl/ntt_dit_controller.sv | 194 +++++++++++++++++++
 tb/tb_ntt_dit_controller.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_dit_controller.sv
// Address sequencer for an in-place radix-2 DIT NTT: one butterfly per cycle,
// a LAT-deep write-back address pipeline and a drain gap between stages.
module ntt_dit_controller #(
  parameter int LOGN = 8,
  parameter int LAT  = 2,
  localparam int SW  = $clog2(LOGN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  output logic            busy,
  output logic            done,
  output logic [SW-1:0]   stage,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr0,
  output logic [LOGN-1:0] rd_addr1,
  output logic [LOGN-2:0] tw_addr,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr0,
  output logic [LOGN-1:0] wr_addr1,
  output logic [1:0]      dbg_state
);

  // Handshake: start is a level sampled only in IDLE; abort is sampled on every
  // clock edge and overrides everything else. rd_en and wr_en are one-cycle
  // strobes with their addresses valid in the same cycle; there is no ready.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int CW = (LOGN > 4) ? LOGN : 4;
  localparam logic [CW-1:0] C_LAST = CW'((2 ** (LOGN - 1)) - 1);
  localparam logic [CW-1:0] D_LAST = CW'(LAT - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [SW-1:0]   r_stage;
  logic [SW-1:0]   w_stage_nxt;

  logic            r_rd_en;
  logic [LOGN-1:0] r_rd_addr0;
  logic [LOGN-1:0] r_rd_addr1;
  logic [LOGN-2:0] r_tw_addr;

  logic [LAT-1:0]  r_pv;
  logic [LOGN-1:0] r_pa0 [LAT];
  logic [LOGN-1:0] r_pa1 [LAT];

  logic [LOGN-1:0] w_c_ext;
  logic [LOGN-1:0] w_bit;
  logic [LOGN-1:0] w_j;
  logic [LOGN-1:0] w_i0;
  logic [LOGN-1:0] w_i1;
  logic [LOGN-2:0] w_tw;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_stage <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stage <= w_stage_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stage_nxt = r_stage;
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_stage_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
            w_stage_nxt = '0;
          end
        end
        S_RUN: begin
          if (r_cnt == C_LAST) begin
            w_state_nxt = S_DRAIN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          if (r_cnt == D_LAST) begin
            w_cnt_nxt = '0;
            if (r_stage == S_LAST) begin
              w_state_nxt = S_DONE;
            end else begin
              w_state_nxt = S_RUN;
              w_stage_nxt = r_stage + SW'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          w_state_nxt = S_IDLE;
          w_stage_nxt = '0;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_stage_nxt = '0;
        end
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
    done      = (r_state == S_DONE);
    stage     = busy ? r_stage : '0;
    dbg_state = r_state;
  end

  // Butterfly addresses for the upcoming cycle, so the registered outputs
  // line up with the RUN cycle that issues them.
  always_comb begin
    w_c_ext = {1'b0, w_cnt_nxt[LOGN-2:0]};
    w_bit   = LOGN'(1) << w_stage_nxt;
    w_j     = w_c_ext & (w_bit - LOGN'(1));
    w_i0    = (((w_c_ext >> w_stage_nxt) << w_stage_nxt) << 1) | w_j;
    w_i1    = w_i0 | w_bit;
    w_tw    = w_j[LOGN-2:0] << (S_LAST - w_stage_nxt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_en    <= 1'b0;
      r_rd_addr0 <= '0;
      r_rd_addr1 <= '0;
      r_tw_addr  <= '0;
    end else begin
      r_rd_en <= (w_state_nxt == S_RUN);
      if (w_state_nxt == S_RUN) begin
        r_rd_addr0 <= w_i0;
        r_rd_addr1 <= w_i1;
        r_tw_addr  <= w_tw;
      end
    end
  end

  // Write-back pipeline; abort drops every in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pv <= '0;
      for (int k = 0; k < LAT; k++) begin
        r_pa0[k] <= '0;
        r_pa1[k] <= '0;
      end
    end else if (abort) begin
      r_pv <= '0;
    end else begin
      r_pv[0]  <= r_rd_en;
      r_pa0[0] <= r_rd_addr0;
      r_pa1[0] <= r_rd_addr1;
      for (int k = 1; k < LAT; k++) begin
        r_pv[k]  <= r_pv[k-1];
        r_pa0[k] <= r_pa0[k-1];
        r_pa1[k] <= r_pa1[k-1];
      end
    end
  end

  assign rd_en    = r_rd_en;
  assign rd_addr0 = r_rd_addr0;
  assign rd_addr1 = r_rd_addr1;
  assign tw_addr  = r_tw_addr;
  assign wr_en    = r_pv[LAT-1];
  assign wr_addr0 = r_pa0[LAT-1];
  assign wr_addr1 = r_pa1[LAT-1];

endmodule

// File: tb/tb_ntt_dit_controller.sv
// Bench for ntt_dit_controller: an 8-point/LAT=2 instance checked cycle by cycle
// and a 16-point/LAT=3 instance driving a modelled RAM and butterfly (Q=65537).
module tb_ntt_dit_controller;

  localparam int LA  = 3;
  localparam int LTA = 2;
  localparam int HA  = 4;
  localparam int TA  = LA * (HA + LTA);
  localparam int LB  = 4;
  localparam int LTB = 3;
  localparam int NB  = 16;
  localparam int TB  = LB * (NB / 2 + LTB);
  localparam longint Q = 65537;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, a_start, a_abort;
  logic a_busy, a_done, a_rd_en, a_wr_en;
  logic [1:0] a_stage, a_tw, a_dbg;
  logic [2:0] a_rd0, a_rd1, a_wr0, a_wr1;

  logic b_rst, b_start, b_abort;
  logic b_busy, b_done, b_rd_en, b_wr_en;
  logic [1:0] b_stage, b_dbg;
  logic [2:0] b_tw;
  logic [3:0] b_rd0, b_rd1, b_wr0, b_wr1;

  ntt_dit_controller #(.LOGN(LA), .LAT(LTA)) u_dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .abort(a_abort),
    .busy(a_busy), .done(a_done), .stage(a_stage),
    .rd_en(a_rd_en), .rd_addr0(a_rd0), .rd_addr1(a_rd1), .tw_addr(a_tw),
    .wr_en(a_wr_en), .wr_addr0(a_wr0), .wr_addr1(a_wr1), .dbg_state(a_dbg)
  );

  ntt_dit_controller #(.LOGN(LB), .LAT(LTB)) u_dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .abort(b_abort),
    .busy(b_busy), .done(b_done), .stage(b_stage),
    .rd_en(b_rd_en), .rd_addr0(b_rd0), .rd_addr1(b_rd1), .tw_addr(b_tw),
    .wr_en(b_wr_en), .wr_addr0(b_wr0), .wr_addr1(b_wr1), .dbg_state(b_dbg)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic a_check_idle(input string tag);
    check_eq({tag, "_busy"}, 32'(a_busy), 32'd0);
    check_eq({tag, "_done"}, 32'(a_done), 32'd0);
    check_eq({tag, "_rd_en"}, 32'(a_rd_en), 32'd0);
    check_eq({tag, "_wr_en"}, 32'(a_wr_en), 32'd0);
    check_eq({tag, "_stage"}, 32'(a_stage), 32'd0);
  endtask

  // Butterfly list for one transform: in stage s, the upper inputs are the
  // indices with bit s clear, ascending; twiddle is (i0 mod 2^s) scaled to N.
  task automatic build_model_a();
    exp_q.delete();
    for (int s = 0; s < LA; s++) begin
      for (int i = 0; i < (1 << LA); i++) begin
        if (((i >> s) & 1) == 0) begin
          int i1, tw;
          i1 = i + (1 << s);
          tw = (i % (1 << s)) * (1 << (LA - 1 - s));
          exp_q.push_back({3'(i), 3'(i1), 2'(tw)});
        end
      end
    end
  endtask

  // Starts one transform on instance A and checks every cycle until IDLE.
  // inject_t: cycle at which a stray start is pulsed (-1 none);
  // abort_t: cycle at which abort is raised (-1 none).
  task automatic a_run(input int inject_t, input int abort_t);
    logic [7:0] wq[$];
    logic [7:0] item, last_rd;
    bit exp_run, exp_wr, exp_busy;
    build_model_a();
    wq = exp_q;
    last_rd = '0;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int t = 0; t <= TA; t++) begin
      exp_busy = (t < TA);
      exp_run  = exp_busy && ((t % (HA + LTA)) < HA);
      exp_wr   = (t >= LTA) && (((t - LTA) % (HA + LTA)) < HA);
      check_eq("busy", 32'(a_busy), 32'(exp_busy));
      check_eq("done", 32'(a_done), 32'(t == TA));
      check_eq("rd_en", 32'(a_rd_en), 32'(exp_run));
      check_eq("wr_en", 32'(a_wr_en), 32'(exp_wr));
      if (exp_busy) check_eq("stage", 32'(a_stage), 32'(t / (HA + LTA)));
      if (exp_run) begin
        item = exp_q.pop_front();
        check_eq("rd_addrs", 32'({a_rd0, a_rd1, a_tw}), 32'(item));
        last_rd = item;
      end else if (t > 0) begin
        check_eq("rd_hold", 32'({a_rd0, a_rd1, a_tw}), 32'(last_rd));
      end
      if (exp_wr) begin
        item = wq.pop_front();
        check_eq("wr_addrs", 32'({a_wr0, a_wr1}), 32'(item[7:2]));
      end
      if (t == abort_t) begin
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        for (int k = 0; k < 25; k++) begin
          a_check_idle("abort_quiet");
          @(negedge clk);
        end
        return;
      end
      a_start = (t == inject_t);
      @(negedge clk);
    end
    a_start = 1'b0;
    a_check_idle("after_done");
  endtask

  function automatic longint modpow(input longint b, input longint e);
    longint r, bb, ee;
    r = 1; bb = b % Q; ee = e;
    while (ee > 0) begin
      if (ee[0]) r = (r * bb) % Q;
      bb = (bb * bb) % Q;
      ee = ee >> 1;
    end
    return r;
  endfunction

  function automatic int bitrev4(input int v);
    return ((v & 1) << 3) | ((v & 2) << 1) | ((v & 4) >> 1) | ((v & 8) >> 3);
  endfunction

  // Full 16-point transform on instance B against a direct O(N^2) NTT.
  task automatic b_ntt(input bit rand_data);
    longint x[NB], mem[NB], wp[NB], gold[NB];
    longint w, av, bv, tv;
    longint pv0[$], pv1[$];
    int pa0[$], pa1[$];
    int t;
    bit got_done;
    w = modpow(3, (Q - 1) / NB);
    wp[0] = 1;
    for (int i = 1; i < NB; i++) wp[i] = (wp[i-1] * w) % Q;
    for (int n = 0; n < NB; n++) x[n] = rand_data ? longint'($urandom_range(0, 65536)) : longint'(n + 1);
    for (int k = 0; k < NB; k++) begin
      gold[k] = 0;
      for (int n = 0; n < NB; n++) gold[k] = (gold[k] + x[n] * wp[(n * k) % NB]) % Q;
    end
    for (int i = 0; i < NB; i++) mem[i] = x[bitrev4(i)];
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    t = 0;
    got_done = 1'b0;
    while (!got_done && t < 100) begin
      if (b_rd_en) begin
        av = mem[b_rd0];
        bv = mem[b_rd1];
        tv = (wp[b_tw] * bv) % Q;
        pv0.push_back((av + tv) % Q);
        pv1.push_back((av + Q - tv) % Q);
        pa0.push_back(int'(b_rd0));
        pa1.push_back(int'(b_rd1));
      end
      if (b_wr_en) begin
        if (pa0.size() == 0) begin
          check_eq("b_wr_spurious", 32'(b_wr_en), 32'd0);
        end else begin
          check_eq("b_wr_addr0", 32'(b_wr0), 32'(pa0.pop_front()));
          check_eq("b_wr_addr1", 32'(b_wr1), 32'(pa1.pop_front()));
          mem[b_wr0] = pv0.pop_front();
          mem[b_wr1] = pv1.pop_front();
        end
      end
      if (b_done) begin
        got_done = 1'b1;
        check_eq("b_done_cycle", 32'(t), 32'(TB));
      end else begin
        t++;
        @(negedge clk);
      end
    end
    if (!got_done) check_eq("b_done_timeout", 32'd0, 32'd1);
    check_eq("b_pipe_left", 32'(pa0.size()), 32'd0);
    for (int k = 0; k < NB; k++) check_eq("b_ntt_coef", 32'(mem[k]), 32'(gold[k]));
    @(negedge clk);
    check_eq("b_idle_busy", 32'(b_busy), 32'd0);
  endtask

  initial begin
    a_rst = 1'b1; a_start = 1'b0; a_abort = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_abort = 1'b0;
    repeat (2) @(negedge clk);
    a_check_idle("reset");
    check_eq("reset_rd_addrs", 32'({a_rd0, a_rd1, a_tw}), 32'd0);
    check_eq("reset_wr_addrs", 32'({a_wr0, a_wr1}), 32'd0);
    check_eq("reset_b_busy", 32'(b_busy), 32'd0);
    check_eq("reset_b_rd_en", 32'(b_rd_en), 32'd0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);

    a_run(-1, -1);
    a_run(HA - 2, -1);
    a_run(TA, -1);
    a_run(-1, HA + LTA + 2);
    a_run(-1, -1);

    a_start = 1'b1;
    a_abort = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_abort = 1'b0;
    a_check_idle("abort_vs_start");
    @(negedge clk);
    a_check_idle("abort_vs_start2");

    // Asynchronous reset in the first drain cycle of stage 0
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    repeat (HA) @(negedge clk);
    check_eq("pre_rst_wr_en", 32'(a_wr_en), 32'd1);
    #2 a_rst = 1'b1;
    #1;
    a_check_idle("async_rst");
    check_eq("async_rst_rd_addrs", 32'({a_rd0, a_rd1, a_tw}), 32'd0);
    check_eq("async_rst_wr_addrs", 32'({a_wr0, a_wr1}), 32'd0);
    @(negedge clk);
    a_rst = 1'b0;
    @(negedge clk);
    a_check_idle("post_rst");
    a_run(-1, -1);

    for (int r = 0; r < 4; r++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      for (int g = 0; g < gap; g++) begin
        a_check_idle("gap");
        @(negedge clk);
      end
      a_run(int'($urandom_range(0, TA)), -1);
    end

    b_ntt(1'b0);
    b_ntt(1'b1);
    b_ntt(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
